pipelined_adder_tree: RTL and testbench
=======================================

Name: pipelined_adder_tree

Overview:
Parametrised, pipelined, signed adder tree with a multi-beat accumulator and saturating output. It reduces LENGTH fixed-point operands per beat. It accumulates consecutive beats until in_last, producing one dot-product partial sum per neuron. It sits between the multiplier array and the activation unit, with a valid/ready handshake on both sides.

Parameters:
- Q_SIZE, 16: operand and result width, signed two's complement.
- LENGTH, 8: operands per beat, any value >= 1 (power of 2 not required).
- REG_STRIDE, 1: a pipeline register is inserted after every REG_STRIDE tree levels (>= 1).
- ACC_GUARD, 8: extra accumulator bits beyond tree growth.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LENGTH x Q_SIZE  packed operand vector, signed
- in_last  in  1  final beat of the current accumulation
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  Q_SIZE  saturated accumulated sum
- out_sat  out  1  out_data was clipped

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Derived constants:
  - LEVELS = clog2(LENGTH), which is 0 when LENGTH = 1.
  - NREG = ceil(LEVELS / REG_STRIDE).
  - ACC_W = Q_SIZE + LEVELS + ACC_GUARD.
- Tree structure:
  - Operands are padded with zeros to 2^LEVELS and reduced pairwise.
  - Each node is sign-extended by one bit per level, so there is no overflow inside the tree.
- Pipeline registers:
  - Registers sit after levels REG_STRIDE, 2*REG_STRIDE, ... and always after the last level when LEVELS > 0.
  - Each register stage carries a valid bit and a last bit alongside the data.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational.
  - A beat is accepted on an edge where in_valid && in_ready.
  - While stall is high, every pipeline register, the accumulator and the output register hold.
  - Bubbles propagate normally when there is no stall.
- Accumulator stage, acting on tree-output beats with valid = 1:
  - acc_next = (first ? 0 : acc) + sign-extended tree sum, in ACC_W bits.
  - first = 1 after reset and after every last beat, and 0 otherwise.
  - If the beat is not last: acc <= acc_next, first <= 0. No output.
  - If the beat is last: out_data <= sat(acc_next), out_sat <= clipped, out_valid <= 1, first <= 1.
- Saturation:
  - acc_next > 2^(Q_SIZE-1) - 1 gives the maximum positive value, with out_sat = 1.
  - acc_next < -2^(Q_SIZE-1) gives the minimum negative value, with out_sat = 1.
- Output register:
  - out_valid clears on an edge where out_ready is high and no new result is loaded.
  - A simultaneous handshake plus a new result replaces out_data and keeps out_valid = 1.
- Latency:
  - A last beat accepted on edge k produces out_valid = 1 after edge k + NREG, with no stalls.
  - LENGTH = 1 gives latency edge k.
- Throughput: one beat per cycle while out_ready = 1.
- Reset values:
  - out_valid = 0, out_data = 0, out_sat = 0.
  - All stage valids = 0, acc = 0, first = 1.
  - in_ready = 1.
- Reset mid-operation: in-flight beats and any partial accumulation are discarded. No output results from them.
- Result ordering: results emerge in acceptance order and are never dropped or duplicated under back-pressure.
- in_last with in_valid = 0 is ignored.

Decomposition:
- adder_pkg holds:
  - the clog2 function;
  - functions for levels, register count and accumulator width;
  - the saturating-truncate function returning the value and the clip flag.
- Sub-module adder_tree_level:
  - one reduction level, parametrised by input count and input width;
  - optional output register with valid/last and hold-enable;
  - instantiated LEVELS times in a generate loop.

Test Plan:
- Single-beat sum (Q_SIZE=16, LENGTH=8): one last beat with operands 1..8 -> out_data=36, out_sat=0, out_valid after edge k+3.
- Non-power-of-2 padding (LENGTH=5): operands {-3,7,0,2,-1}, last -> out_data=5. Same beat with REG_STRIDE=2 -> latency 2 edges.
- Multi-beat accumulation: three back-to-back beats of all ones, last on the third -> exactly one result, out_data=24; no out_valid after beats 1-2.
- Saturation: all 0x7FFF -> 0x7FFF with out_sat=1. All 0x8000 -> 0x8000 with out_sat=1. Operands {0x7FFF,1,-1,0,...} -> 0x7FFF with out_sat=0.
- Back-pressure: stream 6 single-beat results (sums 1..6) while out_ready is held low for 4 cycles mid-stream.
  - in_ready drops and out_data stays stable while stalled.
  - Results are received as exactly 1..6, in order.
- Reset mid-accumulation: send 2 of 3 ones beats, pulse rst_n low asynchronously between edges.
  - out_valid=0 immediately.
  - After release, one last beat of all ones -> out_data=8, not 24.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder tree: sizing functions
// and the saturating truncation applied to the accumulated sum.
package adder_pkg;

  localparam int SAT_MAX_W = 64;
  localparam int WIDE_W    = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic                 clip;
    logic [SAT_MAX_W-1:0] value;
  } sat_t;

  // Returns 0 for n <= 1, so a single-operand tree has no levels.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int calc_levels(input int length);
    return clog2(length);
  endfunction

  function automatic int calc_nreg(input int levels, input int stride);
    return (levels + stride - 1) / stride;
  endfunction

  function automatic int calc_acc_w(input int q_size, input int levels, input int guard);
    return q_size + levels + guard;
  endfunction

  // Clamp v into a q-bit signed range; the low q bits of .value are the result.
  function automatic sat_t sat_trunc(input wide_t v, input int q);
    wide_t max_v;
    wide_t min_v;
    sat_t  res;
    max_v = (wide_t'(1) <<< (q - 1)) - wide_t'(1);
    min_v = -max_v - wide_t'(1);
    res.clip = 1'b0;
    if (v > max_v) begin
      res.value = max_v[SAT_MAX_W-1:0];
      res.clip  = 1'b1;
    end else if (v < min_v) begin
      res.value = min_v[SAT_MAX_W-1:0];
      res.clip  = 1'b1;
    end else begin
      res.value = v[SAT_MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One pairwise reduction level of the adder tree: N_IN signed operands of
// W_IN bits become N_IN/2 sums of W_IN+1 bits, optionally registered.
module adder_tree_level #(
  parameter int N_IN  = 2,
  parameter int W_IN  = 16,
  parameter bit REG   = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             hold,
  input  logic                             in_valid,
  input  logic                             in_last,
  input  logic [N_IN*W_IN-1:0]             in_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic [(N_IN/2)*(W_IN+1)-1:0]     out_data
);

  localparam int N_OUT = N_IN / 2;
  localparam int W_OUT = W_IN + 1;

  logic [N_OUT*W_OUT-1:0] sum;

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic [W_IN-1:0] a;
    logic [W_IN-1:0] b;
    assign a = in_data[(2*j)*W_IN +: W_IN];
    assign b = in_data[(2*j+1)*W_IN +: W_IN];
    // One bit of sign extension per level keeps every sum exact.
    assign sum[j*W_OUT +: W_OUT] = {a[W_IN-1], a} + {b[W_IN-1], b};
  end

  if (REG) begin : g_reg
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (!hold) begin
        out_valid <= in_valid;
        out_last  <= in_last;
      end
    end

    // NOTE: only the control bits need reset; data is qualified by out_valid,
    // so leaving the wide datapath unreset saves reset routing.
    always_ff @(posedge clk) begin
      if (!hold) out_data <= sum;
    end
  end else begin : g_comb
    assign out_valid = in_valid;
    assign out_last  = in_last;
    assign out_data  = sum;

    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, hold};
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with multi-beat accumulation and a saturating,
// back-pressured output register.
module pipelined_adder_tree
  import adder_pkg::*;
#(
  parameter int Q_SIZE     = 16,
  parameter int LENGTH     = 8,
  parameter int REG_STRIDE = 1,
  parameter int ACC_GUARD  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LENGTH*Q_SIZE-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Q_SIZE-1:0]        out_data,
  output logic                     out_sat
);

  localparam int LEVELS = calc_levels(LENGTH);
  localparam int ACC_W  = calc_acc_w(Q_SIZE, LEVELS, ACC_GUARD);
  localparam int P2     = 1 << LEVELS;
  localparam int PAD_W  = P2 * Q_SIZE;
  localparam int TREE_W = Q_SIZE + LEVELS;

  logic                     stall;
  logic                     accept;
  logic signed [TREE_W-1:0] tree_sum;
  logic                     tree_valid;
  logic                     tree_last;

  // A held output freezes the whole pipeline, so nothing is dropped or reordered.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  if (LEVELS == 0) begin : g_flat
    assign tree_sum   = in_data;
    assign tree_valid = accept;
    assign tree_last  = in_last && accept;
  end else begin : g_tree
    logic [LEVELS:0][PAD_W-1:0] link;
    logic [LEVELS:0]            link_v;
    logic [LEVELS:0]            link_l;

    // Missing operands are zero-padded up to the next power of two.
    assign link[0]   = PAD_W'(in_data);
    assign link_v[0] = accept;
    assign link_l[0] = in_last && accept;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int N_IN  = P2 >> l;
      localparam int W_IN  = Q_SIZE + l;
      localparam int OUT_W = (N_IN / 2) * (W_IN + 1);
      localparam bit REG   = (((l + 1) % REG_STRIDE) == 0) || (l == LEVELS - 1);

      logic [OUT_W-1:0] d_out;

      adder_tree_level #(
        .N_IN (N_IN),
        .W_IN (W_IN),
        .REG  (REG)
      ) u_level (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (stall),
        .in_valid  (link_v[l]),
        .in_last   (link_l[l]),
        .in_data   (link[l][N_IN*W_IN-1:0]),
        .out_valid (link_v[l+1]),
        .out_last  (link_l[l+1]),
        .out_data  (d_out)
      );

      assign link[l+1] = PAD_W'(d_out);
    end

    assign tree_sum   = link[LEVELS][TREE_W-1:0];
    assign tree_valid = link_v[LEVELS];
    assign tree_last  = link_l[LEVELS];

    logic unused_link;
    assign unused_link = ^link;
  end

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic                    first;
  sat_t                    sat_res;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    acc_next = (first ? '0 : acc) + ACC_W'(tree_sum);
    sat_res  = sat_trunc(wide_t'(acc_next), Q_SIZE);
  end

  logic unused_sat;
  assign unused_sat = ^sat_res.value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      // Not stalled means the current result is either absent or being taken.
      out_valid <= tree_valid && tree_last;
      if (tree_valid) begin
        if (tree_last) begin
          out_data <= sat_res.value[Q_SIZE-1:0];
          out_sat  <= sat_res.clip;
          first    <= 1'b1;
        end else begin
          acc   <= acc_next;
          first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: directed beats push expected
// results, an independent monitor pops and compares on each output handshake.
`timescale 1ns/1ps
module tb_pipelined_adder_tree;

  localparam int Q = 16;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, in_last;
  logic [L*Q-1:0] in_data;
  logic           out_valid, out_ready, out_sat;
  logic [Q-1:0]   out_data;

  pipelined_adder_tree #(.Q_SIZE(Q), .LENGTH(L), .REG_STRIDE(1), .ACC_GUARD(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  // Auxiliary configurations for padding, stride and single-operand latency.
  logic           a_valid, a_last;
  logic [5*Q-1:0] a5_data;
  logic [Q-1:0]   a1_data;
  logic           r5s1, r5s2, r1;
  logic           v5s1, v5s2, v1;
  logic           s5s1, s5s2, s1;
  logic [Q-1:0]   d5s1, d5s2, d1;

  pipelined_adder_tree #(.Q_SIZE(Q), .LENGTH(5), .REG_STRIDE(1), .ACC_GUARD(8)) dut_5s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(r5s1), .in_data(a5_data),
    .in_last(a_last), .out_valid(v5s1), .out_ready(1'b1), .out_data(d5s1), .out_sat(s5s1)
  );
  pipelined_adder_tree #(.Q_SIZE(Q), .LENGTH(5), .REG_STRIDE(2), .ACC_GUARD(8)) dut_5s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(r5s2), .in_data(a5_data),
    .in_last(a_last), .out_valid(v5s2), .out_ready(1'b1), .out_data(d5s2), .out_sat(s5s2)
  );
  pipelined_adder_tree #(.Q_SIZE(Q), .LENGTH(1), .REG_STRIDE(1), .ACC_GUARD(8)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(r1), .in_data(a1_data),
    .in_last(a_last), .out_valid(v1), .out_ready(1'b1), .out_data(d1), .out_sat(s1)
  );

  typedef struct packed {
    logic [Q-1:0] data;
    logic         sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   stall_samples = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one beat and wait (bounded) for acceptance; optionally push a result.
  task automatic send(input logic [L*Q-1:0] d, input logic last, input logic push,
                      input logic [Q-1:0] ed, input logic es);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      #4;
      ok = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("send_accept", ok, 1'b1);
    if (ok && push) sb.push_back('{ed, es});
  endtask

  // Monitor: samples just before each rising edge, after all drives settle.
  initial begin
    logic         held_valid;
    logic [Q-1:0] held;
    exp_t         e;
    held_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        held_valid = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          stall_samples++;
          check("stall_in_ready", in_ready, 1'b0);
          if (held_valid) check("stall_hold", out_data, held);
          held = out_data;
          held_valid = 1'b1;
        end else begin
          held_valid = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("result_data", out_data, e.data);
            check("result_sat", out_sat, e.sat);
          end
        end
      end
    end
  end

  initial begin
    int lat, l5s1, l5s2, l1, stall0;
    logic [Q-1:0] g5s1, g5s2, g1;
    logic [L*Q-1:0] ones;

    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    a_valid = 1'b0; a_last = 1'b0;
    a5_data = {16'hFFFF, 16'd2, 16'd0, 16'd7, 16'hFFFD};
    a1_data = 16'h1234;
    ones = {L{16'd1}};

    #12;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 16'h0);
    check("reset_out_sat", out_sat, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Padding, stride and LENGTH=1 latency on the auxiliary instances.
    @(negedge clk);
    a_valid = 1'b1; a_last = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_last = 1'b0;
    l5s1 = -1; l5s2 = -1; l1 = -1;
    g5s1 = '0; g5s2 = '0; g1 = '0;
    for (int i = 0; i < 8; i++) begin
      if (v5s1 && l5s1 < 0) begin l5s1 = i; g5s1 = d5s1; end
      if (v5s2 && l5s2 < 0) begin l5s2 = i; g5s2 = d5s2; end
      if (v1 && l1 < 0) begin l1 = i; g1 = d1; end
      @(posedge clk);
      #1;
    end
    check("len5_s1_latency", l5s1, 3);
    check("len5_s1_data", g5s1, 16'd5);
    check("len5_s2_latency", l5s2, 2);
    check("len5_s2_data", g5s2, 16'd5);
    check("len1_latency", l1, 0);
    check("len1_data", g1, 16'h1234);

    // Single-beat sum 1..8 and its latency.
    send({16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b1, 16'd36, 1'b0);
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      #4;
      if (out_valid) begin lat = i - 1; break; end
    end
    check("single_beat_latency", lat, 3);
    repeat (4) @(negedge clk);

    // Three-beat accumulation; only the last beat produces a result.
    send(ones, 1'b0, 1'b0, 16'd0, 1'b0);
    send(ones, 1'b0, 1'b0, 16'd0, 1'b0);
    send(ones, 1'b1, 1'b1, 16'd24, 1'b0);

    // Saturation boundaries.
    send({L{16'h7FFF}}, 1'b1, 1'b1, 16'h7FFF, 1'b1);
    send({L{16'h8000}}, 1'b1, 1'b1, 16'h8000, 1'b1);
    send({16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd1, 16'h7FFF}, 1'b1, 1'b1, 16'h7FFF, 1'b0);
    repeat (6) @(negedge clk);

    // Back-pressure: out_ready low for 4 cycles while streaming sums 1..6.
    stall0 = stall_samples;
    fork
      begin
        for (int n = 1; n <= 6; n++)
          send((L*Q)'(n), 1'b1, 1'b1, Q'(n), 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    check("stall_exercised", stall_samples > stall0, 1'b1);
    repeat (8) @(negedge clk);

    // Reset mid-accumulation discards the partial sum.
    send(ones, 1'b0, 1'b0, 16'd0, 1'b0);
    send(ones, 1'b0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_out_data", out_data, 16'h0);
    check("midreset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    send(ones, 1'b1, 1'b1, 16'd8, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
